lab2_addsub_arbiter: RTL and testbench

Two-requester arbiter and sequencer for one shared `lab2_adder_subtractor_parametrizable` instance. It accepts add/subtract requests over valid/ready handshakes and grants the datapath round-robin. It latches operands, drives the shared adder/subtractor for one cycle, and returns the registered result on a per-requester response channel with backpressure. It sits between the lab2 datapath and any two clients (e.g. a control FSM and a test/UI port) that must time-share one adder.

---
 rtl/lab2_addsub_pkg.sv | 15 +
 rtl/lab2_adder_subtractor_parametrizable.sv | 28 ++
 rtl/lab2_addsub_arbiter.sv | 134 +++++++++++++
 tb/tb_lab2_addsub_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_addsub_pkg.sv
// Shared definitions for the lab2 add/subtract arbiter.
//   state_e    : sequencer states (IDLE, EXEC, RESP)
//   REQ0, REQ1 : requester IDs used for owner tagging and the round-robin pointer
package lab2_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/lab2_adder_subtractor_parametrizable.sv
// Combinational WIDTH-bit adder/subtractor.
//   a_i, b_i : operands
//   k_i      : 0 = a+b, 1 = a-b (two's complement: a + ~b + 1)
//   sum_o    : result modulo 2^WIDTH
//   cout_o   : carry-out; on subtract 1 means no borrow (a >= b unsigned)
//   ovf_o    : two's-complement signed overflow
module lab2_adder_subtractor_parametrizable #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             k_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] beff;
    logic [WIDTH:0]   full;

    assign beff   = b_i ^ {WIDTH{k_i}};
    assign full   = {1'b0, a_i} + {1'b0, beff} + {{WIDTH{1'b0}}, k_i};
    assign sum_o  = full[WIDTH-1:0];
    assign cout_o = full[WIDTH];
    // Overflow: both effective operands share a sign that the result does not.
    assign ovf_o  = (a_i[WIDTH-1] == beff[WIDTH-1]) & (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/lab2_addsub_arbiter.sv
// Two-requester round-robin arbiter/sequencer around one shared adder/subtractor.
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/a/b/k         : request N handshake and operands (k: 0 add, 1 sub)
//   reqN_ready               : request N accepted this cycle (IDLE only)
//   rspN_valid/ready         : response N handshake, held until consumed
//   rspN_sum/cout/ovf        : registered result (shared registers, owner-tagged)
module lab2_addsub_arbiter
    import lab2_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_k,
    output logic             req0_ready,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_sum,
    output logic             rsp0_cout,
    output logic             rsp0_ovf,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_k,
    output logic             req1_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_sum,
    output logic             rsp1_cout,
    output logic             rsp1_ovf
);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             k_q, k_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;
    logic             load_res;

    logic [WIDTH-1:0] alu_sum;
    logic             alu_cout, alu_ovf;
    logic             grant0, grant1;

    lab2_adder_subtractor_parametrizable #(.WIDTH(WIDTH)) u_addsub (
        .a_i    (a_q),
        .b_i    (b_q),
        .k_i    (k_q),
        .sum_o  (alu_sum),
        .cout_o (alu_cout),
        .ovf_o  (alu_ovf)
    );

    // On a tie the requester not served last wins.
    assign grant0 = req0_valid & (~req1_valid | (last_q == REQ1));
    assign grant1 = req1_valid & (~req0_valid | (last_q == REQ0));

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        k_d        = k_q;
        load_res   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = ~rst & grant0;
                req1_ready = ~rst & grant1;
                if (req0_ready | req1_ready) begin
                    owner_d = req1_ready ? REQ1 : REQ0;
                    last_d  = owner_d;
                    a_d     = req1_ready ? req1_a : req0_a;
                    b_d     = req1_ready ? req1_b : req0_b;
                    k_d     = req1_ready ? req1_k : req0_k;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                load_res = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                rsp0_valid = ~rst & (owner_q == REQ0);
                rsp1_valid = ~rst & (owner_q == REQ1);
                if (((owner_q == REQ0) & rsp0_ready) | ((owner_q == REQ1) & rsp1_ready))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= REQ1;
            owner_q <= REQ0;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            if (load_res) begin
                sum_q  <= alu_sum;
                cout_q <= alu_cout;
                ovf_q  <= alu_ovf;
            end
        end
    end

    assign rsp0_sum  = sum_q;
    assign rsp0_cout = cout_q;
    assign rsp0_ovf  = ovf_q;
    assign rsp1_sum  = sum_q;
    assign rsp1_cout = cout_q;
    assign rsp1_ovf  = ovf_q;

endmodule

// File: tb/tb_lab2_addsub_arbiter.sv
// Self-checking bench for lab2_addsub_arbiter (WIDTH=4): directed scenarios
// followed by randomized traffic, all checked against a transaction-level model.
module tb_lab2_addsub_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_k = 1'b0, req1_k = 1'b0;
    logic         req0_ready, req1_ready;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [W-1:0] rsp0_sum, rsp1_sum;
    logic         rsp0_cout, rsp1_cout, rsp0_ovf, rsp1_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    lab2_addsub_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_k     (req0_k),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_sum   (rsp0_sum),
        .rsp0_cout  (rsp0_cout),
        .rsp0_ovf   (rsp0_ovf),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_k     (req1_k),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_sum   (rsp1_sum),
        .rsp1_cout  (rsp1_cout),
        .rsp1_ovf   (rsp1_ovf)
    );

    always #5 clk = ~clk;

    // Requesters must hold operands while valid and not yet accepted.
    logic       h0 = 1'b0, h1 = 1'b0;
    logic [8:0] p0 = '0, p1 = '0;
    always @(posedge clk) begin
        if (h0 && req0_valid)
            assert ({req0_a, req0_b, req0_k} == p0) else $error("req0 operands changed while pending");
        if (h1 && req1_valid)
            assert ({req1_a, req1_b, req1_k} == p1) else $error("req1 operands changed while pending");
        h0 <= req0_valid && !req0_ready;
        h1 <= req1_valid && !req1_ready;
        p0 <= {req0_a, req0_b, req0_k};
        p1 <= {req1_a, req1_b, req1_k};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: one operation in flight, response visible
    // from the second cycle after accept until consumed.
    bit           m_busy  = 1'b0;
    int           m_age   = 0;
    bit           m_owner = 1'b0;
    bit           m_last  = 1'b1;
    logic [W-1:0] m_sum   = '0;
    bit           m_cout  = 1'b0, m_ovf = 1'b0;
    bit           acc0, acc1, hs0, hs1;
    logic [W-1:0] o_sum;
    bit           o_cout, o_ovf;

    task automatic expect_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic k);
        int ai, bi, sa, sb, r, sr;
        ai = int'(a);
        bi = int'(b);
        sa = (ai >= 8) ? ai - 16 : ai;
        sb = (bi >= 8) ? bi - 16 : bi;
        if (k) begin
            r = ai - bi; sr = sa - sb; m_cout = (ai >= bi);
        end else begin
            r = ai + bi; sr = sa + sb; m_cout = (r >= 16);
        end
        m_sum = 4'((r + 16) % 16);
        m_ovf = (sr > 7) || (sr < -8);
    endtask

    task automatic model_step();
        bit g0, g1, er0, er1, ev0, ev1;
        g0  = req0_valid && (!req1_valid || m_last == 1'b1);
        g1  = req1_valid && (!req0_valid || m_last == 1'b0);
        er0 = !rst && !m_busy && g0;
        er1 = !rst && !m_busy && g1;
        ev0 = !rst && m_busy && m_age >= 2 && m_owner == 1'b0;
        ev1 = !rst && m_busy && m_age >= 2 && m_owner == 1'b1;
        check_eq("req0_ready", req0_ready, er0);
        check_eq("req1_ready", req1_ready, er1);
        check_eq("rsp0_valid", rsp0_valid, ev0);
        check_eq("rsp1_valid", rsp1_valid, ev1);
        if (ev0) begin
            check_eq("rsp0_sum", rsp0_sum, m_sum);
            check_eq("rsp0_cout", rsp0_cout, m_cout);
            check_eq("rsp0_ovf", rsp0_ovf, m_ovf);
        end
        if (ev1) begin
            check_eq("rsp1_sum", rsp1_sum, m_sum);
            check_eq("rsp1_cout", rsp1_cout, m_cout);
            check_eq("rsp1_ovf", rsp1_ovf, m_ovf);
        end
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        hs0  = rsp0_valid && rsp0_ready;
        hs1  = rsp1_valid && rsp1_ready;
        if (hs0) begin o_sum = rsp0_sum; o_cout = rsp0_cout; o_ovf = rsp0_ovf; end
        if (hs1) begin o_sum = rsp1_sum; o_cout = rsp1_cout; o_ovf = rsp1_ovf; end
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (m_busy) begin
            if ((ev0 && rsp0_ready) || (ev1 && rsp1_ready)) m_busy = 1'b0;
            else if (m_age < 2) m_age++;
        end else if (er0 || er1) begin
            m_owner = er1;
            m_last  = er1;
            m_busy  = 1'b1;
            m_age   = 1;
            if (er1) expect_op(req1_a, req1_b, req1_k);
            else     expect_op(req0_a, req0_b, req0_k);
        end
    endtask

    // Check at the falling edge, then return just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (4) cycle();
    endtask

    task automatic do_op(input int who, input logic [W-1:0] a, input logic [W-1:0] b, input logic k,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        bit done;
        int n;
        if (who == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_k = k; end
        else          begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_k = k; end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            done = (who == 0) ? acc0 : acc1;
        end
        check_eq("op_accept", done, 1);
        if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        done = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            n++;
            done = (who == 0) ? hs0 : hs1;
        end
        check_eq("op_response", done, 1);
        check_eq("op_latency", n, 2);
        check_eq("op_sum", o_sum, es);
        check_eq("op_cout", o_cout, ec);
        check_eq("op_ovf", o_ovf, eo);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    initial begin
        // Reset with both requesters valid.
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd4;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check_eq("reset_sum0", rsp0_sum, 0);
        check_eq("reset_sum1", rsp1_sum, 0);
        cycle();
        check_eq("first_grant0", acc0, 1);
        check_eq("first_grant1", acc1, 0);
        drain();

        // Add with overflow; subtract with and without borrow.
        do_op(0, 4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b1);
        do_op(1, 4'd2, 4'd5, 1'b1, 4'd13, 1'b0, 1'b0);
        do_op(1, 4'd5, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
        do_op(0, 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0);
        do_op(1, 4'd8, 4'd1, 1'b1, 4'd7, 1'b1, 1'b1);

        // Fair arbitration under continuous contention.
        begin
            int prev, prev_t;
            prev = -1;
            prev_t = 0;
            req0_valid = 1'b1; req0_a = 4'($urandom); req0_b = 4'($urandom); req0_k = 1'($urandom);
            req1_valid = 1'b1; req1_a = 4'($urandom); req1_b = 4'($urandom); req1_k = 1'($urandom);
            rsp0_ready = 1'b1;
            rsp1_ready = 1'b1;
            for (int t = 0; t < 16; t++) begin
                cycle();
                if (acc0 || acc1) begin
                    if (prev >= 0) begin
                        check_eq("fair_alt", acc1, prev == 0);
                        check_eq("fair_ii", t - prev_t, 3);
                    end
                    prev = acc1 ? 1 : 0;
                    prev_t = t;
                    if (acc1) begin req1_a = 4'($urandom); req1_b = 4'($urandom); req1_k = 1'($urandom); end
                    else      begin req0_a = 4'($urandom); req0_b = 4'($urandom); req0_k = 1'($urandom); end
                end
            end
            check_eq("fair_seen", prev >= 0, 1);
            drain();
        end

        // Backpressure on requester 0 while requester 1 waits.
        begin
            bit got;
            rsp0_ready = 1'b0;
            rsp1_ready = 1'b0;
            req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd1; req0_k = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin cycle(); got = acc0; end
            check_eq("bp_accept", got, 1);
            req0_valid = 1'b0;
            req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd9; req1_k = 1'b1;
            repeat (5) begin
                cycle();
                check_eq("bp_req1_blocked", acc1, 0);
            end
            check_eq("bp_hold_sum", rsp0_sum, 8);
            check_eq("bp_hold_valid", rsp0_valid, 1);
            rsp0_ready = 1'b1;
            cycle();
            check_eq("bp_handshake", hs0, 1);
            cycle();
            check_eq("bp_req1_next", acc1, 1);
            req1_valid = 1'b0;
            drain();
        end

        // Reset during EXEC discards the operation and restores the pointer.
        begin
            bit got;
            do_op(0, 4'd4, 4'd4, 1'b0, 4'd8, 1'b0, 1'b1);
            req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd3; req0_k = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin cycle(); got = acc0; end
            check_eq("rmid_accept", got, 1);
            req0_valid = 1'b0;
            rsp0_ready = 1'b1;
            rsp1_ready = 1'b1;
            rst = 1'b1;
            cycle();
            rst = 1'b0;
            check_eq("rmid_sum_cleared", rsp0_sum, 0);
            repeat (4) cycle();
            req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_k = 1'b0;
            req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2; req1_k = 1'b0;
            cycle();
            check_eq("rmid_tie_grant0", acc0, 1);
            check_eq("rmid_tie_grant1", acc1, 0);
            drain();
        end

        // Randomized traffic with occasional resets and withdrawals.
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!(req0_valid && !acc0)) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_a = 4'($urandom); req0_b = 4'($urandom); req0_k = 1'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req0_valid = 1'b0;
            end
            if (!(req1_valid && !acc1)) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_a = 4'($urandom); req1_b = 4'($urandom); req1_k = 1'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req1_valid = 1'b0;
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
